// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-width codes, FSM states and
// the alignment/legality helpers used when a request is accepted.
package lsu_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ONE,
    SPLIT,
    RESP
  } lsu_state_t;

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      LS_H, LS_HU: return addr_lo[0];
      LS_W:        return addr_lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Unsigned widths only exist for loads; 011/110/111 are never legal.
  function automatic logic is_illegal(input logic write, input logic [2:0] funct3);
    case (funct3)
      LS_B, LS_H, LS_W: return 1'b0;
      LS_BU, LS_HU:     return write;
      default:          return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of an assembled halfword: h sign-extends, everything else zero-extends.
// Purely combinational, no latency, no flow control.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [15:0] half_val,
  input  logic [2:0]  funct3,
  output logic [31:0] ext_val
);

  always_comb begin
    ext_val = {16'h0000, half_val};
    if (funct3 == LS_H) ext_val = {{16{half_val[15]}}, half_val};
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one request per handshake, aligned = 2 cycles, split h/w = 3/5, error = 1.
// req_ready only in IDLE; the response is a one-cycle pulse with no backpressure.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_val,
  output logic        mem_write_en,
  output logic        mem_read_en,
  output logic [2:0]  mem_data_size,
  input  logic [31:0] mem_rd_val
);

  lsu_state_t  state, state_nxt;
  logic        r_write;
  logic [31:0] r_addr, r_wdata;
  logic [2:0]  r_funct3;
  logic [1:0]  idx, idx_last;
  logic [31:0] asm_q;
  logic        err_q, ext_q;
  logic        req_illegal, req_mis, req_reject;
  logic [31:0] ext_val;

  assign req_illegal = is_illegal(req_write, req_funct3);
  assign req_mis     = is_misaligned(req_funct3, req_addr[1:0]);
  assign req_reject  = req_illegal | (req_mis & ~SPLIT_MISALIGNED);

  lsu_load_extend u_extend (
    .half_val (asm_q[15:0]),
    .funct3   (r_funct3),
    .ext_val  (ext_val)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_funct3 <= '0;
      idx      <= '0;
      idx_last <= '0;
      asm_q    <= '0;
      err_q    <= 1'b0;
      ext_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          r_write  <= req_write;
          r_addr   <= req_addr;
          r_wdata  <= req_wdata;
          r_funct3 <= req_funct3;
          idx      <= 2'd0;
          idx_last <= (req_funct3 == LS_W) ? 2'd3 : 2'd1;
          asm_q    <= '0;
          err_q    <= req_reject;
          // Only split halfword loads need extending here; aligned ones arrive extended.
          ext_q    <= req_mis & ~req_write & (req_funct3 != LS_W);
        end
        ONE: if (!r_write) asm_q <= mem_rd_val;
        SPLIT: begin
          idx <= idx + 2'd1;
          if (!r_write) asm_q[{idx, 3'b000} +: 8] <= mem_rd_val[7:0];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt     = state;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_rdata    = '0;
    resp_err      = 1'b0;
    mem_addr      = '0;
    mem_wr_val    = '0;
    mem_write_en  = 1'b0;
    mem_read_en   = 1'b0;
    mem_data_size = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_reject)   state_nxt = RESP;
          else if (req_mis) state_nxt = SPLIT;
          else              state_nxt = ONE;
        end
      end
      ONE: begin
        mem_addr      = r_addr;
        mem_data_size = r_funct3;
        mem_wr_val    = r_wdata;
        mem_write_en  = r_write;
        mem_read_en   = ~r_write;
        state_nxt     = RESP;
      end
      SPLIT: begin
        mem_addr      = r_addr + {30'd0, idx};
        mem_data_size = r_write ? LS_B : LS_BU;
        mem_wr_val    = r_wdata >> {idx, 3'b000};
        mem_write_en  = r_write;
        mem_read_en   = ~r_write;
        if (idx == idx_last) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = ext_q ? ext_val : asm_q;
        resp_err   = err_q;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage of the pipeline, sitting directly upstream of `DataMemory`. It accepts one load or store per handshake from the execute stage and issues the `DataMemory` access with the RISC-V width code. Naturally aligned accesses pass straight through. Misaligned accesses are split into a sequence of byte accesses, and loads are reassembled and sign- or zero-extended before a single response is returned.

## Interface
Parameters:
- `SPLIT_MISALIGNED`, default 1: 1 splits misaligned accesses into byte accesses; 0 rejects them with `resp_err`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; the low bytes are used.
- `req_funct3`  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu.
- `resp_valid`  out  1  one-cycle completion pulse, for loads and stores.
- `resp_rdata`  out  32  extended load data; 0 for stores.
- `resp_err`  out  1  with `resp_valid`: illegal funct3, or misaligned access when `SPLIT_MISALIGNED`=0.
- `mem_addr`  out  32  to `DataMemory` `mem_access_addr`.
- `mem_wr_val`  out  32  to `mem_wr_val`.
- `mem_write_en`  out  1  to `mem_write_en`.
- `mem_read_en`  out  1  to `mem_read_en`.
- `mem_data_size`  out  3  to `mem_data_size`.
- `mem_rd_val`  in  32  from `mem_rd_val`. It is combinational from address/size and sampled at the edge ending the access cycle.

## Operation
- **Reset values:** every output is 0 except `req_ready`, which is 1; state is IDLE.
- **Misalignment rule:**
  - h/hu are misaligned when `addr[0]`=1.
  - w is misaligned when `addr[1:0]`≠0.
  - b/bu are never misaligned.
  - Stores use funct3 000/001/010 only. A store with 100/101, and any 011/110/111, is illegal.
- **States:**
  - IDLE: `req_ready`=1. On `req_valid`, latch write/addr/wdata/funct3.
    - Illegal, or misaligned with `SPLIT_MISALIGNED`=0 → RESP with err=1.
    - Aligned → ONE.
    - Otherwise → SPLIT with idx=0 and n=2 (h) or 4 (w).
  - ONE: a single cycle driving `mem_addr`=addr, `mem_data_size`=funct3, `mem_wr_val`=wdata, and the matching enable.
    - `DataMemory` already extends aligned loads, so `mem_rd_val` is captured unchanged.
    - → RESP.
  - SPLIT: one byte access per cycle.
    - `mem_addr` = addr+idx, wrapping mod 2^32.
    - Stores use `mem_data_size`=000 with `mem_wr_val` = wdata>>(8·idx).
    - Loads use `mem_data_size`=100 and capture `mem_rd_val[7:0]` into byte idx of the assembly register.
    - idx increments each cycle; after idx=n−1 → RESP.
  - RESP: `resp_valid`=1 for one cycle with `resp_rdata` and `resp_err` valid; `req_ready`=0 → IDLE.
- **Split-load extension:** h sign-extends from bit 15; hu zero-extends.
- Only one of `mem_write_en`/`mem_read_en` is ever high. Both are 0 in IDLE and RESP, and for error requests.
- `mem_addr`/`mem_wr_val`/`mem_data_size` hold 0 when no access is active.
- **Reset mid-operation:** all outputs return to reset values immediately and the request is dropped with no response. A split store may be left partially written; this is accepted behaviour.

## Timing
- Handshake: `req_valid` && `req_ready` at edge E0 accepts the request. `req_ready` is low from E0 until the cycle after RESP, so back-to-back accepts are never possible.
- Aligned: access in cycle 1, `resp_valid` in cycle 2 → 2-cycle latency.
- Misaligned h: 2 access cycles, `resp_valid` in cycle 3. Misaligned w: 4 access cycles, `resp_valid` in cycle 5.
- Error: `resp_valid` in cycle 1, with no memory access.
- Response has no backpressure; the consumer must take `resp_valid` when it is high.

## Structure
- Package `lsu_pkg`:
  - funct3 constants `LS_B`, `LS_H`, `LS_W`, `LS_BU`, `LS_HU`.
  - the state enum (IDLE, ONE, SPLIT, RESP).
  - function `is_misaligned(funct3, addr[1:0])`.
- Sub-module `lsu_load_extend`: combinational; takes the assembled 16-bit value and funct3 and produces the extended 32-bit result. It is also used by the bench's reference model.

## Test plan
- **Aligned lw:** memory words 0x0=c4c3c2c1, 0x4=d4d3d2d1, 0x8=e4e3e2e1.
  - lw 0x4 → one read, size 010, `resp_rdata`=d4d3d2d1 in cycle 2.
- **Misaligned lw 0x5:** same contents → four reads at 5, 6, 7, 8 with size 100; `resp_rdata`=e1d4d3d2 in cycle 5.
- **Misaligned halfwords:** lh 0x7 → reads 7, 8; `resp_rdata`=ffffe1d4. lhu 0x7 → 0000e1d4. lh 0x3 → ffffd1c4.
- **Misaligned sw:** zeroed memory, sw 0x6 with f7f6f5f4 → four byte writes. Word 0x4=f5f40000, word 0x8=0000f7f6, `resp_rdata`=0.
- **Errors:**
  - funct3=011 → `resp_valid`+`resp_err` in cycle 1, no enables.
  - `SPLIT_MISALIGNED`=0 with lw 0x5 → err, no access.
  - sw with funct3 100 → err.
- **Reset mid-operation:** assert `reset_n`=0 during SPLIT idx=1 of sw 0x5.
  - Enables drop in the same cycle and no `resp_valid` follows.
  - After release, `req_ready`=1, and a following aligned lw 0x4 completes correctly.
